// File: rtl/pulse_pkg.sv
// pulse_pkg
//   Shared definitions for the pulse stretcher: FSM state encoding,
//   default parameter values and a helper for sizing the phase counter.
//   No ports; imported with `import pulse_pkg::*;`.
package pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int DEF_TICK_DIV   = 250;
  localparam int DEF_HIGH_TICKS = 4;
  localparam int DEF_GAP_TICKS  = 4;
  localparam int DEF_PEND_W     = 4;

  // Bits needed to hold 0..max(high_ticks, gap_ticks).
  function automatic int phase_width(input int high_ticks, input int gap_ticks);
    int m;
    m = (high_ticks > gap_ticks) ? high_ticks : gap_ticks;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen
//   Free-running prescaler counting 0..TICK_DIV-1 and emitting a one-cycle
//   tick on the last count. A restart request forces the count back to 0
//   on the next clock so that the first cycle of a new phase sees count 0.
// Ports
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   restart : restart the count from 0 on the next edge
//   tick    : high for one cycle when count == TICK_DIV-1
module tick_gen
  import pulse_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher
//   Turns single-cycle event requests into stretched output pulses of
//   HIGH_TICKS ticks high followed by GAP_TICKS ticks low. Requests arriving
//   while a pulse is in progress are queued in a saturating counter and
//   replayed back to back; requests that find the queue full are dropped
//   and flagged in a sticky overflow bit.
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   pulse_in  : single-cycle event request
//   clr_ovf   : clears the overflow flag
//   pulse_out : registered stretched pulse (high exactly in HIGH)
//   busy      : high whenever the FSM is not IDLE
//   pending   : queued events not yet emitted
//   ovf       : sticky, an event was dropped because pending was full
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int HIGH_TICKS = DEF_HIGH_TICKS,
  parameter int GAP_TICKS  = DEF_GAP_TICKS,
  parameter int PEND_W     = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  input  logic              clr_ovf,
  output logic              pulse_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              ovf
);

  localparam int PH_W = phase_width(HIGH_TICKS, GAP_TICKS);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              ovf_q, ovf_d;
  logic              pulse_out_q, pulse_out_d;

  logic tick;
  logic restart;
  logic high_done;
  logic gap_done;
  logic consume;
  logic queue_req;
  logic drop;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    consume   = 1'b0;
    drop      = 1'b0;

    high_done = tick && (phase_q == PH_W'(HIGH_TICKS - 1));
    gap_done  = tick && (phase_q == PH_W'(GAP_TICKS - 1));

    unique case (state_q)
      ST_IDLE: begin
        // A queued event left over from a GAP->IDLE request starts here too.
        if (pulse_in || (pending_q != '0)) begin
          state_d = ST_HIGH;
        end
        consume = (pending_q != '0);
      end
      ST_HIGH: begin
        if (high_done) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          consume = (pending_q != '0);
          state_d = consume ? ST_HIGH : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An IDLE request with nothing queued starts the pulse directly;
    // every other request goes through the pending counter.
    queue_req = pulse_in && !((state_q == ST_IDLE) && (pending_q == '0));

    if (queue_req && !consume) begin
      if (pending_q == PEND_MAX) begin
        drop = 1'b1;
      end else begin
        pending_d = pending_q + PEND_W'(1);
      end
    end else if (!queue_req && consume) begin
      pending_d = pending_q - PEND_W'(1);
    end

    // A new drop wins over a clear in the same cycle.
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end

    // Every state entry, including GAP->HIGH, restarts both counters.
    restart = (state_d != state_q);
    if (restart) begin
      phase_d = '0;
    end else if (tick && (state_q != ST_IDLE)) begin
      phase_d = phase_q + PH_W'(1);
    end

    pulse_out_d = (state_d == ST_HIGH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      pending_q   <= '0;
      ovf_q       <= 1'b0;
      pulse_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      pending_q   <= pending_d;
      ovf_q       <= ovf_d;
      pulse_out_q <= pulse_out_d;
    end
  end

  assign pulse_out = pulse_out_q;
  assign busy      = (state_q != ST_IDLE);
  assign pending   = pending_q;
  assign ovf       = ovf_q;

endmodule
